// File: rtl/dm_arbiter.sv
// dm_arbiter
// ----------
// Two-port arbiter and access sequencer in front of a 1024-word data memory
// (word index Addr[11:2], combinational read, write on the rising edge).
// Port 0 is the CPU load/store path, port 1 a secondary master (debug/DMA).
// Each transaction runs IDLE -> ACCESS -> DONE: the winner is latched in
// IDLE, the memory is touched for exactly one cycle in ACCESS, and a single
// cycle Ack (with Err) is returned in DONE.
//
// Configuration macro:
//   DM_ARB_RR_EN  defined   -> round-robin on a conflict, 1-bit pointer holds
//                              the last granted port
//                 undefined -> fixed priority, port 0 wins every conflict
//
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   ReqN, WrN, AddrN, WDataN request side of port N (held until after AckN)
//   AckN, ErrN, RDataN      completion pulse, error flag, registered load data
//   M_MemWrite, M_MemRead   memory strobes, only ever high in ACCESS
//   M_Addr, M_Din           memory address / store data (owner's values)
//   M_Dout                  memory read data
//   Busy                    FSM not in IDLE
//   Owner                   port currently granted (valid in ACCESS/DONE)

module dm_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Wr0,
  input  logic [31:0] Addr0,
  input  logic [31:0] WData0,
  input  logic        Req1,
  input  logic        Wr1,
  input  logic [31:0] Addr1,
  input  logic [31:0] WData1,
  output logic        Ack0,
  output logic        Err0,
  output logic [31:0] RData0,
  output logic        Ack1,
  output logic        Err1,
  output logic [31:0] RData1,
  output logic        M_MemWrite,
  output logic        M_MemRead,
  output logic [31:0] M_Addr,
  output logic [31:0] M_Din,
  input  logic [31:0] M_Dout,
  output logic        Busy,
  output logic        Owner
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

`ifdef DM_ARB_RR_EN
  logic        rrPtr_q, rrPtr_d;
`endif

  logic        ownWr;
  logic [31:0] ownAddr;
  logic        addrBad;
  logic        grant;
  logic        inAccess;

  // The memory always sees the owner's address and data so they stay stable
  // outside ACCESS as well; only the strobes are qualified by state.
  always_comb begin
    ownWr   = owner_q ? Wr1    : Wr0;
    ownAddr = owner_q ? Addr1  : Addr0;
    M_Din   = owner_q ? WData1 : WData0;
  end

  assign M_Addr   = ownAddr;
  assign addrBad  = (ownAddr[1:0] != 2'b00) || (ownAddr >= ADDR_LIMIT);
  assign inAccess = (state_q == StAccess);

  // Winner of the current IDLE cycle; only consulted when some request is up.
`ifdef DM_ARB_RR_EN
  // On a conflict the port that did not win last time gets the grant.
  always_comb begin
    if (Req0 && Req1) begin
      grant = ~rrPtr_q;
    end else begin
      grant = Req1;
    end
  end
`else
  assign grant = !Req0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef DM_ARB_RR_EN
    rrPtr_d  = rrPtr_q;
`endif
    case (state_q)
      StIdle: begin
        if (Req0 || Req1) begin
          state_d = StAccess;
          owner_d = grant;
`ifdef DM_ARB_RR_EN
          rrPtr_d = grant;
`endif
        end
      end
      StAccess: begin
        state_d = StDone;
        err_d   = addrBad;
        // Only a successful load refreshes the owner's read register.
        if (!ownWr && !addrBad) begin
          if (owner_q) begin
            rdata1_d = M_Dout;
          end else begin
            rdata0_d = M_Dout;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
`ifdef DM_ARB_RR_EN
      rrPtr_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef DM_ARB_RR_EN
      rrPtr_q  <= rrPtr_d;
`endif
    end
  end

  // Strobes are gated by Reset so an aborted ACCESS never commits a write.
  assign M_MemWrite = !Reset && inAccess && !addrBad && ownWr;
  assign M_MemRead  = !Reset && inAccess && !addrBad && !ownWr;

  assign Ack0   = (state_q == StDone) && !owner_q;
  assign Ack1   = (state_q == StDone) && owner_q;
  assign Err0   = Ack0 && err_q;
  assign Err1   = Ack1 && err_q;
  assign RData0 = rdata0_q;
  assign RData1 = rdata1_q;
  assign Busy   = (state_q != StIdle);
  assign Owner  = owner_q;

endmodule
